serial_adder: RTL and testbench

- Bit-serial N-bit adder; the additive counterpart to the team's half-subtractor datapath.
- Captures two operands on a start pulse and processes one bit per clock, LSB first, through a single registered carry.
- Returns the sum and carry-out with a busy/done handshake.
- Intended for area-constrained arithmetic paths where latency is acceptable.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/serial_adder_if.sv | 20 ++
 rtl/fa_cell.sv | 12 +
 rtl/serial_adder.sv | 70 +++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding, default width and counter sizing helper
package serial_arith_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result response of the serial adder
//   master drives start, a, b (and sub when SERIAL_ADDER_SUB_EN is defined)
//   slave drives busy, done, sum, cout
interface serial_adder_if #(parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub;
  modport master(output start, a, b, sub, input busy, done, sum, cout);
  modport slave(input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master(output start, a, b, input busy, done, sum, cout);
  modport slave(input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/fa_cell.sv
// fa_cell: combinational full-adder bit cell
//   a, b, cin -> s (sum bit), cout (majority carry)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock LSB first through one registered carry
//   clk, rst_n (async active-low); bus (slave): start, a, b -> busy, done, sum, cout
//   SERIAL_ADDER_SUB_EN adds bus.sub: a-b with cout reporting borrow
module serial_adder import serial_arith_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic accept, shifting, last, fa_s, fa_co, sub_in, sub_q;
  fa_cell u_fa (.a(a_sr_q[0]), .b(b_sr_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_co));
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_d;
  assign sub_in = bus.sub;
  assign sub_d = accept ? bus.sub : sub_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sub_q <= 1'b0;
    else sub_q <= sub_d;
`else
  assign sub_in = 1'b0;
  assign sub_q = 1'b0;
`endif
  assign shifting = state_q == ST_SHIFT;
  assign accept = !shifting && bus.start;
  assign last = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = shifting ? (last ? ST_DONE : ST_SHIFT) : (bus.start ? ST_SHIFT : ST_IDLE);
  end
  // Subtraction is a + ~b + 1, so the seed carry is the sub flag and the borrow is the inverted carry-out.
  always_comb begin
    a_sr_d = accept ? bus.a : shifting ? a_sr_q >> 1 : a_sr_q;
    b_sr_d = accept ? (sub_in ? ~bus.b : bus.b) : shifting ? b_sr_q >> 1 : b_sr_q;
    carry_d = accept ? sub_in : shifting ? fa_co : carry_q;
    cnt_d = accept ? '0 : shifting ? cnt_q + 1'b1 : cnt_q;
    res_d = shifting ? ({fa_s, {(WIDTH-1){1'b0}}} | (res_q >> 1)) : res_q;
    sum_d = shifting && last ? res_d : sum_q;
    cout_d = shifting && last ? fa_co ^ sub_q : cout_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      res_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      res_q <= res_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
    end
  assign bus.busy = shifting;
  assign bus.done = state_q == ST_DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors against a transaction-level model plus literal expectations
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int pend = 0;
  logic m_done = 1'b0;
  logic m_cout = 1'b0;
  logic op_cout = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W-1:0] op_sum = '0;
  serial_adder_if #(.WIDTH(W)) bus();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: an accepted request completes exactly W edges later; nothing is accepted while one is pending.
  always begin
    logic s;
    logic [W:0] t;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend = 0;
      m_done = 1'b0;
      m_sum = '0;
      m_cout = 1'b0;
    end else begin
      m_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_sum = op_sum;
          m_cout = op_cout;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
`ifdef SERIAL_ADDER_SUB_EN
        s = bus.sub;
`else
        s = 1'b0;
`endif
        t = s ? {1'b0, bus.a} - {1'b0, bus.b} : {1'b0, bus.a} + {1'b0, bus.b};
        op_sum = t[W-1:0];
        op_cout = s ? (bus.a < bus.b) : t[W];
        pend = W;
      end
    end
  end
  always begin
    @(posedge clk);
    #2;
    chk("busy", 64'(bus.busy), 64'(pend > 0));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("sum", 64'(bus.sum), 64'(m_sum));
    chk("cout", 64'(bus.cout), 64'(m_cout));
  end
  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input logic [W-1:0] es, input logic ec);
    int lat, nb;
    lat = -1;
    nb = 0;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sv;
`else
    if (sv) $display("note: %s requested subtract in add-only build", nm);
`endif
    bus.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.a = ~av;
        bus.b = ~bv;
      end
      if (bus.busy) nb++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(W));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(W));
    chk({nm, "_sum"}, 64'(bus.sum), 64'(es));
    chk({nm, "_cout"}, 64'(bus.cout), 64'(ec));
  endtask
  initial begin
    int nd, last_k, k;
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;
    run_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    // A second start while busy must be ignored.
    @(negedge clk);
    bus.a = 8'h10;
    bus.b = 8'h20;
    bus.start = 1'b1;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (i == 2) begin
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.start = 1'b1;
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) nd++;
    end
    chk("ignore_done_count", 64'(nd), 64'd1);
    chk("ignore_sum", 64'(bus.sum), 64'h30);
    // Reset in the middle of an operation.
    @(negedge clk);
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_sum", 64'(bus.sum), 64'd0);
    chk("abort_cout", 64'(bus.cout), 64'd0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (bus.done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run_op("add_07_09", 8'h07, 8'h09, 1'b0, 8'h10, 1'b0);
    // Start held high: each accept takes the operands present on that edge.
    ta = '{8'h12, 8'h80, 8'hFF, 8'h7F};
    tb = '{8'h34, 8'h80, 8'h00, 8'h01};
    @(negedge clk);
    k = 0;
    bus.a = ta[0];
    bus.b = tb[0];
    bus.start = 1'b1;
    nd = 0;
    last_k = -1;
    for (int i = 0; i < 60 && nd < 4; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last_k >= 0) chk("b2b_period", 64'(i - last_k), 64'(W + 1));
        last_k = i;
        nd++;
      end
      if (bus.busy && !bus.done && k < 3 && dut.cnt_q == '0) begin
        k++;
        bus.a = ta[k];
        bus.b = tb[k];
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", 64'(nd), 64'd4);
    chk("b2b_last_sum", 64'(bus.sum), 64'h80);
    chk("b2b_last_cout", 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1);
    run_op("sub_09_03", 8'h09, 8'h03, 1'b1, 8'h06, 1'b0);
    run_op("sub_off_09_03", 8'h09, 8'h03, 1'b0, 8'h0C, 1'b0);
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
